// File: rtl/div_seq_pkg.sv
// ============================================================================
// Module  : div_seq_pkg
// Brief   : Shared constants and state encoding for the iterative divider.
//           Optional build macro DIV_EARLY_OUT_EN: when defined, a divide whose
//           divisor magnitude exceeds the dividend magnitude skips the
//           iterations and completes one cycle after acceptance.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package div_seq_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module  : div_step
// Brief   : One combinational restoring-division iteration on {rem,quo}.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted_d;
    logic [WIDTH:0] diff_d;

    // Partial remainder stays below the divisor, so WIDTH+1 bits never overflow.
    assign shifted_d = {rem_i, quo_i[WIDTH-1]};
    assign diff_d    = shifted_d - {1'b0, divisor_i};

    always_comb begin
        if (!diff_d[WIDTH]) begin
            rem_o = diff_d[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted_d[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module  : div_seq
// Brief   : Multi-cycle DIV/DIVU sequencer with pipeline stall request.
//           Build macro DIV_EARLY_OUT_EN enables the |divisor|>|dividend| bypass.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             startE,
    input  logic             signedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    input  logic             cancel,
    output logic             stall_div,
    output logic             div_valid,
    output logic [WIDTH-1:0] div_hi,
    output logic [WIDTH-1:0] div_lo
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic             negq_q, negr_q;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             neg_a_d, neg_b_d;
    logic [WIDTH-1:0] mag_a_d, mag_b_d;
    logic [WIDTH-1:0] rem_d, quo_d;

    assign neg_a_d = signedE & srcaE[WIDTH-1];
    assign neg_b_d = signedE & srcbE[WIDTH-1];
    assign mag_a_d = neg_a_d ? -srcaE : srcaE;
    assign mag_b_d = neg_b_d ? -srcbE : srcbE;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (rem_d),
        .quo_o     (quo_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DIV_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (startE && !cancel) begin
                        negq_q <= neg_a_d ^ neg_b_d;
                        negr_q <= neg_a_d;
                        dvs_q  <= mag_b_d;
                        cnt_q  <= '0;
`ifdef DIV_EARLY_OUT_EN
                        if (mag_b_d > mag_a_d) begin
                            // Quotient is zero; remainder is the dividend itself.
                            lo_q    <= '0;
                            hi_q    <= neg_a_d ? -mag_a_d : mag_a_d;
                            state_q <= DIV_DONE;
                        end else
`endif
                        begin
                            quo_q   <= mag_a_d;
                            rem_q   <= '0;
                            state_q <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    if (cancel) begin
                        state_q <= DIV_IDLE;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            lo_q    <= negq_q ? -quo_d : quo_d;
                            hi_q    <= negr_q ? -rem_d : rem_d;
                            state_q <= DIV_DONE;
                        end
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

    // Stall drops in DONE so the divide retires from E in that cycle.
    assign stall_div = ((state_q == DIV_IDLE) && startE && !cancel) || (state_q == DIV_BUSY);
    assign div_valid = (state_q == DIV_DONE) && !cancel;
    assign div_hi    = hi_q;
    assign div_lo    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module  : tb_div_seq
// Brief   : Self-checking bench for div_seq (directed + random vs arithmetic model).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, startE, signedE, cancel;
    logic [W-1:0] srcaE, srcbE;
    logic         stall_div, div_valid;
    logic [W-1:0] div_hi, div_lo;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_valid_cyc;
    logic [W-1:0] prev_lo, prev_hi;

    div_seq dut (
        .clk       (clk),
        .rst       (rst),
        .startE    (startE),
        .signedE   (signedE),
        .srcaE     (srcaE),
        .srcbE     (srcbE),
        .cancel    (cancel),
        .stall_div (stall_div),
        .div_valid (div_valid),
        .div_hi    (div_hi),
        .div_lo    (div_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Arithmetic reference: C-style truncating division, x/0 gives all-ones quotient.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi);
        longint sa, sb;
        if (b == 0) begin
            lo = (s && a[W-1]) ? 32'd1 : 32'hFFFF_FFFF;
            hi = a;
        end else if (!s) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end
    endfunction

    function automatic int exp_latency(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        longint ma, mb;
        ma = s ? longint'($signed(a)) : longint'(a);
        mb = s ? longint'($signed(b)) : longint'(b);
        if (ma < 0) ma = -ma;
        if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
        if (mb > ma) return 1;
`endif
        return W + 1;
    endfunction

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input bit keep, input string tag);
        logic [W-1:0] elo, ehi;
        int  lat, stalls, elat;
        bit  seen;
        model(a, b, s, elo, ehi);
        elat = exp_latency(a, b, s);
        @(posedge clk); #1;
        startE = 1'b1; signedE = s; srcaE = a; srcbE = b;
        lat = 0; stalls = 0; seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (div_valid) begin
                seen = 1;
                lat  = n;
                last_valid_cyc = cyc;
                chk({tag, " stall_in_done"}, {31'd0, stall_div}, 32'd0);
                chk({tag, " lo"}, div_lo, elo);
                chk({tag, " hi"}, div_hi, ehi);
            end else begin
                if (stall_div) stalls++;
                @(posedge clk); #1;
                srcaE = $urandom; srcbE = $urandom;
            end
        end
        chk({tag, " pulse_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " stall_cycles"}, 32'(stalls), 32'(elat));
        prev_lo = elo; prev_hi = ehi;
        if (!keep) begin
            @(posedge clk); #1;
            startE = 1'b0;
        end
    endtask

    initial begin
        int  c1;
        bit  any_valid;
        logic [W-1:0] ra, rb;
        rst = 1'b1; startE = 1'b0; signedE = 1'b0; cancel = 1'b0; srcaE = '0; srcbE = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst valid", {31'd0, div_valid}, 32'd0);
        chk("rst stall", {31'd0, stall_div}, 32'd0);
        chk("rst hi", div_hi, 32'd0);
        chk("rst lo", div_lo, 32'd0);

        // Directed arithmetic cases
        run_div(32'd100, 32'd7, 1'b0, 0, "divu100_7");
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "div-7_2");
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "div_ovf");
        run_div(32'h0000_1234, 32'd0, 1'b0, 0, "divu_by0");

        // Cancel at BUSY cycle 10
        @(posedge clk); #1;
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd3;
        repeat (10) begin @(posedge clk); #1; end
        cancel = 1'b1; startE = 1'b0;
        @(negedge clk);
        chk("cancel stall_busy", {31'd0, stall_div}, 32'd1);
        @(posedge clk); #1 cancel = 1'b0;
        @(negedge clk);
        chk("cancel stall_after", {31'd0, stall_div}, 32'd0);
        chk("cancel lo_kept", div_lo, prev_lo);
        chk("cancel hi_kept", div_hi, prev_hi);
        any_valid = 0;
        repeat (40) begin @(negedge clk); if (div_valid) any_valid = 1; end
        chk("cancel no_pulse", {31'd0, any_valid}, 32'd0);
        run_div(32'd9, 32'd3, 1'b0, 0, "divu9_3");

        // Back-to-back pair
        run_div(32'd50, 32'd5, 1'b0, 1, "b2b_first");
        c1 = last_valid_cyc;
        run_div(32'd51, 32'd5, 1'b0, 0, "b2b_second");
        chk("b2b spacing", 32'(last_valid_cyc - c1), 32'd34);

        // Reset mid-BUSY
        @(posedge clk); #1;
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd51; srcbE = 32'd5;
        repeat (5) begin @(posedge clk); #1; end
        rst = 1'b1; startE = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst stall", {31'd0, stall_div}, 32'd0);
        chk("midrst valid", {31'd0, div_valid}, 32'd0);
        chk("midrst hi", div_hi, 32'd0);
        chk("midrst lo", div_lo, 32'd0);
        any_valid = 0;
        repeat (40) begin @(negedge clk); if (div_valid) any_valid = 1; end
        chk("midrst no_pulse", {31'd0, any_valid}, 32'd0);

        // Small dividend / large divisor (early-out candidate)
        run_div(32'd3, 32'd10, 1'b0, 0, "divu3_10");

        // Randomized operands
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            case ($urandom % 4)
                0:       rb = $urandom;
                1:       rb = 32'($urandom % 16);
                2:       rb = 32'd0;
                default: rb = -32'($urandom % 8);
            endcase
            if (i % 6 == 5) ra = 32'($urandom % 64);
            run_div(ra, rb, 1'($urandom % 2), 0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle sequencer for the iterative divide unit serving DIV/DIVU in the execute stage.
- Accepts a divide request from E.
- Holds the pipeline via a stall request while a 32-step restoring division runs.
- Presents quotient and remainder to the HI/LO write path for exactly one cycle.
- Sits beside the ALU.
- stall_div feeds the hazard unit, which converts it into stallF/stallD/stallE.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a power of two.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk
- startE  input  1  divide instruction present in E; held high while that instruction stays in E
- signedE  input  1  1 = DIV (signed), 0 = DIVU; sampled with startE in IDLE
- srcaE  input  WIDTH  dividend; sampled in IDLE when startE=1
- srcbE  input  WIDTH  divisor; sampled in IDLE when startE=1
- cancel  input  1  exception/flush abort; kills an in-flight divide
- stall_div  output  1  pipeline hold request
- div_valid  output  1  one-cycle pulse; results are valid this cycle
- div_hi  output  WIDTH  remainder
- div_lo  output  WIDTH  quotient

Behaviour:
- Reset: state=IDLE, counter=0, div_valid=0, div_hi=0, div_lo=0. stall_div=0 unless startE=1 (stall_div is combinational).
- States: IDLE, BUSY, DONE.
- IDLE:
  - startE=1 and cancel=0: latch operands as magnitudes (signed: two's-complement absolute value).
  - Also latch the sign flags: negq = a[MSB]^b[MSB], negr = a[MSB]; both forced 0 for DIVU.
  - Clear the partial remainder, set counter=0, go to BUSY.
- BUSY:
  - Each cycle, one restoring step: shift {rem,quo} left by 1, trial-subtract the divisor, set quotient LSB on no-borrow.
  - Counter increments each step. After step WIDTH-1 (counter==WIDTH-1), go to DONE.
- DONE:
  - div_valid=1.
  - div_lo = negq ? -quo : quo; div_hi = negr ? -rem : rem. Both registered on the BUSY→DONE edge.
  - Next state is IDLE unconditionally.
- stall_div = (state==IDLE & startE & ~cancel) | state==BUSY. It is 0 in DONE, so the divide retires from E in the DONE cycle.
- Latency: startE seen in IDLE at cycle 0 → BUSY cycles 1..WIDTH → DONE at cycle WIDTH+1. stall_div is high on cycles 0..WIDTH.
- Back-to-back divides: a new startE in the cycle after DONE is accepted normally from IDLE.
- div_hi/div_lo hold their last values until the next DONE; consumers must qualify with div_valid.
- cancel:
  - In BUSY: next state IDLE, no DONE, no div_valid, results unchanged, stall_div drops the following cycle.
  - In IDLE: blocks acceptance.
  - In DONE: suppresses div_valid; result registers still update.
- rst has priority over cancel and startE in every state, including mid-BUSY.
- Divide by zero: no special case; the algorithm runs to completion. DIVU x/0 → lo=all-ones, hi=x. Signed results then have the sign fix applied.
- Signed overflow: 0x80000000 / -1 → lo=0x80000000, hi=0.
- Operand changes on srcaE/srcbE after acceptance are ignored.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- When defined: in IDLE, if |divisor| > |dividend| (magnitudes, unsigned compare), go straight to DONE with quo=0, rem=|dividend|, sign fix applied.
  - Total stall is 1 cycle (cycle 0 only); DONE at cycle 1.
  - Divide by zero never takes this path.
- When undefined: every divide takes the full WIDTH+1-cycle path.

Decomposition:
- Shared package/header holds:
  - state encodings DIV_IDLE=2'b00, DIV_BUSY=2'b01, DIV_DONE=2'b10;
  - default WIDTH/CNT_W constants;
  - the DIV_EARLY_OUT_EN guard documentation.
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: rem, quo, divisor. Outputs: next rem, next quo.
  - Instantiated once; div_seq owns all state, counter, sign handling and stall logic.

Test Plan:
- DIVU 100/7, startE held until stall_div falls → stall_div high 33 cycles; div_valid pulse at cycle 33 with lo=14, hi=2; stall low that cycle.
- DIV -7/2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x1234/0 → lo=0xFFFFFFFF, hi=0x1234 after full latency; no hang.
- cancel asserted at BUSY cycle 10 → IDLE next cycle, no div_valid, div_hi/div_lo keep prior values; a fresh DIVU 9/3 then yields lo=3, hi=0.
- Two DIVU back-to-back (50/5 then 51/5) → two div_valid pulses 34 cycles apart, results (10,0) then (10,1); rst mid-BUSY on the second → all outputs 0 next cycle, no pulse.
- With DIV_EARLY_OUT_EN: DIVU 3/10 → stall 1 cycle, div_valid at cycle 1, lo=0, hi=3. Without it: same stimulus takes 33 stall cycles with the same results.
